comparador_serie_i_d: RTL and testbench

- Sequential, parametrised MSB-first (left-to-right) magnitude comparator.
- Each cycle, K chained left-to-right comparison cells process the next K bits of two latched N-bit operands.
- Propagated "greater"/"less" flags are held in registers, giving an iterative comparator that spans multiple cycles.
- Used wherever wide operands must be compared with a small cell count, with a start/done handshake to the surrounding control logic.

---
 rtl/comparador_serie_i_d.sv | 147 ++++++++++++++
 tb/tb_comparador_serie_i_d.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/comparador_serie_i_d.sv
`default_nettype none
// ============================================================================
// Module   : comparador_serie_i_d
// Purpose  : Iterative MSB-first magnitude comparator. It compares K bits per
//            cycle with a start/done handshake.
//            Optional macro COMP_EARLY_STOP_EN: finish as soon as a difference
//            has been seen.
// Revision : 1.0 - initial release
// ============================================================================
module comparador_serie_i_d #(
  parameter int N      = 8,
  parameter int K      = 1,
  parameter int SIGNED = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a_p,
  input  logic [N-1:0] b_p,
  output logic         busy,
  output logic         done,
  output logic         a_gt_b,
  output logic         a_lt_b,
  output logic         a_eq_b
);

  localparam int STEPS = N / K;
  localparam int CW    = $clog2(STEPS + 1);

`ifdef COMP_EARLY_STOP_EN
  localparam bit EARLY_STOP = 1'b1;
`else
  localparam bit EARLY_STOP = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic            x_q;
  logic            y_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            done_q;
  logic            gt_q;
  logic            lt_q;
  logic            eq_q;

  logic            x_d;
  logic            y_d;
  logic            x_nx;
  logic            y_nx;
  logic            cell_a;
  logic            cell_b;
  logic            finish_d;

  // Chain of K cells over the top K bits; the flags from one cell feed the next.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    x_nx   = x_q;
    y_nx   = y_q;
    cell_a = 1'b0;
    cell_b = 1'b0;
    for (int j = 0; j < K; j++) begin
      cell_a = a_q[N-1-j];
      cell_b = b_q[N-1-j];
      // A set sign bit makes the operand smaller, so swap roles on that bit.
      if ((SIGNED != 0) && (j == 0) && (cnt_q == CW'(STEPS))) begin
        cell_a = b_q[N-1];
        cell_b = a_q[N-1];
      end
      x_nx = x_d | (~y_d & cell_a & ~cell_b);
      y_nx = y_d | (~x_d & ~cell_a & cell_b);
      x_d  = x_nx;
      y_d  = y_nx;
    end
  end

  assign finish_d = (cnt_q == CW'(1)) || (EARLY_STOP && (x_d || y_d));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      x_q     <= 1'b0;
      y_q     <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_q     <= a_p;
            b_q     <= b_p;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            cnt_q   <= CW'(STEPS);
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          x_q   <= x_d;
          y_q   <= y_d;
          a_q   <= a_q << K;
          b_q   <= b_q << K;
          cnt_q <= cnt_q - CW'(1);
          if (finish_d) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            gt_q    <= x_d;
            lt_q    <= y_d;
            eq_q    <= ~x_d & ~y_d;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign a_gt_b = gt_q;
  assign a_lt_b = lt_q;
  assign a_eq_b = eq_q;

endmodule
`default_nettype wire

// File: tb/tb_comparador_serie_i_d.sv
`default_nettype none
// Bench for comparador_serie_i_d. Three instances (K=1 unsigned, K=1 signed,
// K=2 unsigned) share stimulus and are checked every cycle against a model.
module tb_comparador_serie_i_d;

  localparam int ND = 3;
  localparam int KS [ND] = '{1, 1, 2};
  localparam int SS [ND] = '{0, 1, 0};

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a_p   = 8'h00;
  logic [7:0] b_p   = 8'h00;
  logic [ND-1:0] busy_w, done_w, gt_w, lt_w, eq_w;

  int nvec = 0;
  int nerr = 0;

  // Model state: remaining busy cycles, current done, held and pending results.
  int            m_cnt [ND];
  logic [ND-1:0] m_done, m_gt, m_lt, m_eq, p_gt, p_lt, p_eq;

  always #5 clk = ~clk;

  comparador_serie_i_d #(.N(8), .K(1), .SIGNED(0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .start(start), .a_p(a_p), .b_p(b_p),
    .busy(busy_w[0]), .done(done_w[0]), .a_gt_b(gt_w[0]), .a_lt_b(lt_w[0]), .a_eq_b(eq_w[0]));
  comparador_serie_i_d #(.N(8), .K(1), .SIGNED(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a_p(a_p), .b_p(b_p),
    .busy(busy_w[1]), .done(done_w[1]), .a_gt_b(gt_w[1]), .a_lt_b(lt_w[1]), .a_eq_b(eq_w[1]));
  comparador_serie_i_d #(.N(8), .K(2), .SIGNED(0)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start), .a_p(a_p), .b_p(b_p),
    .busy(busy_w[2]), .done(done_w[2]), .a_gt_b(gt_w[2]), .a_lt_b(lt_w[2]), .a_eq_b(eq_w[2]));

  // Busy cycles for one comparison: N/K, or the 1-based chunk holding the
  // first differing bit when early stop is built in.
  function automatic int lat(int k, logic [7:0] a, logic [7:0] b);
    int   r;
    logic found;
    r     = 8 / k;
    found = 1'b0;
`ifdef COMP_EARLY_STOP_EN
    for (int c = 1; c <= 8 / k; c++) begin
      if (!found && (((a ^ b) >> (8 - c * k)) != 8'h00)) begin
        r     = c;
        found = 1'b1;
      end
    end
`endif
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ND; i++) m_cnt[i] = 0;
    m_done = '0; m_gt = '0; m_lt = '0; m_eq = '0;
    p_gt = '0; p_lt = '0; p_eq = '0;
  endtask

  task automatic model_edge();
    logic g, l;
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < ND; i++) begin
        m_done[i] = 1'b0;
        if (m_cnt[i] > 0) begin
          m_cnt[i]--;
          if (m_cnt[i] == 0) begin
            m_done[i] = 1'b1;
            m_gt[i] = p_gt[i]; m_lt[i] = p_lt[i]; m_eq[i] = p_eq[i];
          end
        end else if (start) begin
          if (SS[i] != 0) begin
            g = $signed(a_p) > $signed(b_p);
            l = $signed(a_p) < $signed(b_p);
          end else begin
            g = a_p > b_p;
            l = a_p < b_p;
          end
          p_gt[i] = g; p_lt[i] = l; p_eq[i] = (a_p == b_p);
          m_cnt[i] = lat(KS[i], a_p, b_p);
        end
      end
    end
  endtask

  task automatic chk(string tag, int i, logic obs, logic exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s dut%0d observed=%b expected=%b", tag, i, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < ND; i++) begin
      chk("busy",   i, busy_w[i], (m_cnt[i] > 0));
      chk("done",   i, done_w[i], m_done[i]);
      chk("a_gt_b", i, gt_w[i],   m_gt[i]);
      chk("a_lt_b", i, lt_w[i],   m_lt[i]);
      chk("a_eq_b", i, eq_w[i],   m_eq[i]);
    end
  endtask

  task automatic step(input logic s, input logic [7:0] a, input logic [7:0] b);
    start = s; a_p = a; b_p = b;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Idle cycles with scrambled operand inputs; in-flight comparisons must ignore them.
  task automatic drain(int n);
    for (int c = 0; c < n; c++) step(1'b0, 8'($urandom), 8'($urandom));
  endtask

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_all();
    step(1'b0, 8'h00, 8'h00);
    step(1'b0, 8'h00, 8'h00);
    rst_n = 1'b1;

    // Equal operands: done after N/K busy cycles on every instance.
    step(1'b1, 8'h5A, 8'h5A);
    drain(10);

    // Unsigned vs signed interpretation of the sign bit.
    step(1'b1, 8'h80, 8'h7F);
    drain(10);

    // K=2 instance finishes first, then restarts from its DONE cycle while
    // the K=1 instances are still busy and must ignore the request.
    step(1'b1, 8'h03, 8'h04);
    drain(4);
    step(1'b1, 8'hFF, 8'hFE);
    drain(10);

    // Early-stop candidate: difference in the very first bit.
    step(1'b1, 8'h80, 8'h00);
    drain(10);

    // Start during RUN must not disturb the comparison in flight.
    step(1'b1, 8'h12, 8'h34);
    step(1'b0, 8'h00, 8'h00);
    step(1'b1, 8'h00, 8'hFF);
    step(1'b1, 8'h00, 8'hFF);
    drain(10);

    // Asynchronous reset in the middle of a comparison.
    step(1'b1, 8'hC3, 8'h3C);
    drain(3);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    step(1'b0, 8'h00, 8'h00);
    rst_n = 1'b1;
    drain(12);

    // Random traffic: random start requests, many near-equal operand pairs.
    for (int n = 0; n < 400; n++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? ra ^ 8'(1 << $urandom_range(0, 7)) :
           ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
      step(($urandom_range(0, 2) == 0), ra, rb);
    end
    drain(12);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
